// File: rtl/traffic_defs.sv
// Shared definitions for the traffic lamp monitor: lamp encodings, approach
// indices, fault codes, FSM states and lamp-rule helpers.
package traffic_defs;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;
    localparam logic [2:0] LAMP_DARK   = 3'b000;

    localparam logic [1:0] DIR_S = 2'd0;
    localparam logic [1:0] DIR_W = 2'd1;
    localparam logic [1:0] DIR_N = 2'd2;
    localparam logic [1:0] DIR_E = 2'd3;

    typedef enum logic [2:0] {
        FC_NONE        = 3'd0,
        FC_CONFLICT    = 3'd1,
        FC_ILLEGAL     = 3'd2,
        FC_BAD_TRANS   = 3'd3,
        FC_ROTATION    = 3'd4,
        FC_SHORT_GREEN = 3'd5,
        FC_TIMEOUT     = 3'd6
    } fault_code_e;

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_MONITOR = 2'd1,
        ST_FAULT   = 2'd2
    } state_e;

    function automatic logic lamp_is_illegal(input logic [2:0] lamp);
        return !(lamp inside {LAMP_RED, LAMP_YELLOW, LAMP_GREEN, LAMP_DARK});
    endfunction

    // Yellow may blink (010 <-> 000) before green; green always ends in red.
    function automatic logic lamp_step_legal(input logic [2:0] prev, input logic [2:0] cur);
        if (prev == cur) return 1'b1;
        case ({prev, cur})
            {LAMP_RED,    LAMP_YELLOW},
            {LAMP_YELLOW, LAMP_DARK},
            {LAMP_DARK,   LAMP_YELLOW},
            {LAMP_YELLOW, LAMP_GREEN},
            {LAMP_DARK,   LAMP_GREEN},
            {LAMP_GREEN,  LAMP_RED}:  return 1'b1;
            default:                  return 1'b0;
        endcase
    endfunction

    // Lowest set index wins; callers only use the result when v is nonzero.
    function automatic logic [1:0] lowest_idx(input logic [3:0] v);
        if (v[0])      return DIR_S;
        else if (v[1]) return DIR_W;
        else if (v[2]) return DIR_N;
        else           return DIR_E;
    endfunction

endpackage

// File: rtl/lamp_checker.sv
// Per-approach lamp rule checker: flags illegal encodings, illegal steps
// against the previous sample, and the start of a new green.
module lamp_checker
    import traffic_defs::*;
(
    input  logic [2:0] prev_i,
    input  logic [2:0] cur_i,
    output logic       illegal_o,
    output logic       bad_trans_o,
    output logic       new_green_o
);

    // Illegal encodings mask the transition and new-green checks.
    always_comb begin
        illegal_o   = lamp_is_illegal(cur_i);
        bad_trans_o = !illegal_o && !lamp_step_legal(prev_i, cur_i);
        new_green_o = !illegal_o && (cur_i == LAMP_GREEN) && (prev_i != LAMP_GREEN);
    end

endmodule

// File: rtl/traffic_monitor.sv
// Traffic lamp monitor: checks the four approaches every cycle for encoding,
// transition, conflict, rotation, minimum-green and watchdog faults, latches
// the first fault, pulses grant on legal greens and counts rotations.
module traffic_monitor
    import traffic_defs::*;
#(
    parameter int unsigned TIMEOUT   = 16,
    parameter int unsigned MIN_GREEN = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] N,
    input  logic [2:0] S,
    input  logic [2:0] E,
    input  logic [2:0] W,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [1:0] fault_dir,
    output logic       grant,
    output logic [7:0] rotations
);

    localparam logic [7:0] TIMEOUT_C   = 8'(TIMEOUT);
    localparam logic [7:0] MIN_GREEN_C = 8'(MIN_GREEN);

    logic [3:0][2:0] lamp, prev_q, prev_d;
    logic [3:0]      illegal, bad_trans, new_green, is_green, leaving;
    state_e          state_q, state_d;
    fault_code_e     code_q, code_d, code_c;
    logic [1:0]      dir_q, dir_d, dir_c, last_q, last_d, expect_dir;
    logic            fault_q, fault_d, grant_q, grant_d;
    logic [7:0]      rot_q, rot_d, gcnt_q, gcnt_d, wd_q, wd_d;
    logic [7:0]      gcnt_inc, wd_inc;
    logic [3:0]      rot_bad;

    // Index order matches the fault_dir encoding: S=0, W=1, N=2, E=3.
    assign lamp = {E, N, W, S};

    for (genvar i = 0; i < 4; i++) begin : g_chk
        lamp_checker u_chk (
            .prev_i      (prev_q[i]),
            .cur_i       (lamp[i]),
            .illegal_o   (illegal[i]),
            .bad_trans_o (bad_trans[i]),
            .new_green_o (new_green[i])
        );
        assign is_green[i] = (lamp[i] == LAMP_GREEN);
        assign leaving[i]  = (prev_q[i] == LAMP_GREEN) && (lamp[i] == LAMP_RED);
    end

    assign expect_dir = last_q + 2'd1;
    assign rot_bad    = new_green & ~(4'b0001 << expect_dir);
    assign gcnt_inc   = (gcnt_q == 8'hFF) ? gcnt_q : gcnt_q + 8'd1;
    assign wd_inc     = (wd_q == 8'hFF) ? wd_q : wd_q + 8'd1;

    // Fault classification for this sample, lowest code first.
    always_comb begin
        code_c = FC_NONE;
        dir_c  = '0;
        if (|(is_green & (is_green - 4'd1))) begin
            code_c = FC_CONFLICT;
            dir_c  = lowest_idx(is_green);
        end else if (|illegal) begin
            code_c = FC_ILLEGAL;
            dir_c  = lowest_idx(illegal);
        end else if (|bad_trans) begin
            code_c = FC_BAD_TRANS;
            dir_c  = lowest_idx(bad_trans);
        end else if (|rot_bad) begin
            code_c = FC_ROTATION;
            dir_c  = lowest_idx(rot_bad);
        end else if ((|leaving) && (gcnt_q < MIN_GREEN_C)) begin
            code_c = FC_SHORT_GREEN;
            dir_c  = lowest_idx(leaving);
        end else if ((wd_inc >= TIMEOUT_C) && !(|new_green)) begin
            code_c = FC_TIMEOUT;
            dir_c  = expect_dir;
        end
    end

    // Next-state and registered-output logic; FAULT freezes everything.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        dir_d   = dir_q;
        fault_d = fault_q;
        grant_d = 1'b0;
        rot_d   = rot_q;
        last_d  = last_q;
        gcnt_d  = gcnt_q;
        wd_d    = wd_q;
        prev_d  = prev_q;
        case (state_q)
            ST_INIT, ST_MONITOR: begin
                prev_d = lamp;
                if (code_c != FC_NONE) begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                    code_d  = code_c;
                    dir_d   = dir_c;
                end else if (|new_green) begin
                    // Only one new green can survive the checks: the expected one.
                    state_d = ST_MONITOR;
                    grant_d = 1'b1;
                    last_d  = expect_dir;
                    gcnt_d  = 8'd1;
                    wd_d    = '0;
                    if (last_q == DIR_E) rot_d = rot_q + 8'd1;
                end else begin
                    gcnt_d = (|is_green) ? gcnt_inc : '0;
                    wd_d   = wd_inc;
                end
            end
            ST_FAULT: ;
            default: state_d = ST_INIT;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            code_q  <= FC_NONE;
            dir_q   <= '0;
            fault_q <= 1'b0;
            grant_q <= 1'b0;
            rot_q   <= '0;
            last_q  <= DIR_E;
            gcnt_q  <= '0;
            wd_q    <= '0;
            prev_q  <= {4{LAMP_RED}};
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            dir_q   <= dir_d;
            fault_q <= fault_d;
            grant_q <= grant_d;
            rot_q   <= rot_d;
            last_q  <= last_d;
            gcnt_q  <= gcnt_d;
            wd_q    <= wd_d;
            prev_q  <= prev_d;
        end
    end

    assign fault      = fault_q;
    assign fault_code = code_q;
    assign fault_dir  = dir_q;
    assign grant      = grant_q;
    assign rotations  = rot_q;

endmodule

// File: tb/tb_traffic_monitor.sv
// Directed bench for traffic_monitor: a vector table for one full legal
// rotation plus hand-written sequences for each fault class and reset.
module tb_traffic_monitor;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] D = 3'b000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] N = R, S = R, E = R, W = R;
    logic       fault, grant;
    logic [2:0] fault_code;
    logic [1:0] fault_dir;
    logic [7:0] rotations;

    int checks = 0;
    int errors = 0;
    int grants = 0;

    typedef struct {
        logic       r;
        logic [2:0] s, w, n, e;
        logic       ef;
        logic [2:0] ec;
        logic [1:0] ed;
        logic       eg;
        logic       crot;
        logic [7:0] erot;
    } vec_t;

    vec_t vecs[22];

    traffic_monitor #(.TIMEOUT(16), .MIN_GREEN(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .N          (N),
        .S          (S),
        .E          (E),
        .W          (W),
        .fault      (fault),
        .fault_code (fault_code),
        .fault_dir  (fault_dir),
        .grant      (grant),
        .rotations  (rotations)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic [2:0] s, w, n, e,
                                input logic eg, input logic crot, input logic [7:0] erot);
        vec_t v;
        v.r = r; v.s = s; v.w = w; v.n = n; v.e = e;
        v.ef = 1'b0; v.ec = 3'd0; v.ed = 2'd0; v.eg = eg;
        v.crot = crot; v.erot = erot;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic ef, input logic [2:0] ec,
                             input logic [1:0] ed, input logic eg);
        chk({name, ".fault"}, 8'(fault), 8'(ef));
        chk({name, ".code"},  8'(fault_code), 8'(ec));
        chk({name, ".dir"},   8'(fault_dir), 8'(ed));
        chk({name, ".grant"}, 8'(grant), 8'(eg));
    endtask

    // Apply one sample; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic r, input logic [2:0] s, w, n, e);
        rst = r; S = s; W = w; N = n; E = e;
        @(posedge clk);
        #1;
        if (grant === 1'b1) grants++;
    endtask

    task automatic do_reset();
        step(1'b1, R, R, R, R);
    endtask

    initial begin
        // Legal rotation: yellow 1 cycle, green 4 cycles per approach.
        vecs[0]  = mk(1, R, R, R, R, 0, 1, 8'd0);
        vecs[1]  = mk(0, Y, R, R, R, 0, 0, 8'd0);
        vecs[2]  = mk(0, G, R, R, R, 1, 0, 8'd0);
        vecs[3]  = mk(0, G, R, R, R, 0, 0, 8'd0);
        vecs[4]  = mk(0, G, R, R, R, 0, 0, 8'd0);
        vecs[5]  = mk(0, G, R, R, R, 0, 0, 8'd0);
        vecs[6]  = mk(0, R, Y, R, R, 0, 0, 8'd0);
        vecs[7]  = mk(0, R, G, R, R, 1, 0, 8'd0);
        vecs[8]  = mk(0, R, G, R, R, 0, 0, 8'd0);
        vecs[9]  = mk(0, R, G, R, R, 0, 0, 8'd0);
        vecs[10] = mk(0, R, G, R, R, 0, 0, 8'd0);
        vecs[11] = mk(0, R, R, Y, R, 0, 0, 8'd0);
        vecs[12] = mk(0, R, R, G, R, 1, 0, 8'd0);
        vecs[13] = mk(0, R, R, G, R, 0, 0, 8'd0);
        vecs[14] = mk(0, R, R, G, R, 0, 0, 8'd0);
        vecs[15] = mk(0, R, R, G, R, 0, 0, 8'd0);
        vecs[16] = mk(0, R, R, R, Y, 0, 0, 8'd0);
        vecs[17] = mk(0, R, R, R, G, 1, 0, 8'd0);
        vecs[18] = mk(0, R, R, R, G, 0, 0, 8'd0);
        vecs[19] = mk(0, R, R, R, G, 0, 0, 8'd0);
        vecs[20] = mk(0, R, R, R, G, 0, 0, 8'd0);
        vecs[21] = mk(0, R, R, R, R, 0, 1, 8'd1);

        @(negedge clk);
        grants = 0;
        for (int unsigned i = 0; i < 22; i++) begin
            step(vecs[i].r, vecs[i].s, vecs[i].w, vecs[i].n, vecs[i].e);
            check_out($sformatf("rot[%0d]", i), vecs[i].ef, vecs[i].ec, vecs[i].ed, vecs[i].eg);
            if (vecs[i].crot) chk($sformatf("rot[%0d].rotations", i), rotations, vecs[i].erot);
        end
        chk("rot.grant_count", 8'(grants), 8'd4);

        // Two greens in one sample: conflict, lowest green approach (S).
        do_reset();
        step(0, G, R, G, R);
        check_out("conflict", 1, 3'd1, 2'd0, 0);
        step(0, R, R, R, R);
        step(0, R, Y, R, R);
        check_out("conflict.frozen", 1, 3'd1, 2'd0, 0);

        // W jumps straight from red to green: bad transition on W.
        do_reset();
        step(0, R, G, R, R);
        check_out("badtrans", 1, 3'd3, 2'd1, 0);

        // Illegal encoding on E outranks a bad transition on S.
        do_reset();
        step(0, D, R, R, 3'b111);
        check_out("illegal", 1, 3'd2, 2'd3, 0);

        // First green after reset on W instead of S.
        do_reset();
        step(0, R, Y, R, R);
        check_out("outrot.yellow", 0, 3'd0, 2'd0, 0);
        step(0, R, G, R, R);
        check_out("outrot", 1, 3'd4, 2'd1, 0);

        // Green held only 2 cycles with MIN_GREEN=3.
        do_reset();
        step(0, Y, R, R, R);
        step(0, G, R, R, R);
        check_out("short.grant", 0, 3'd0, 2'd0, 1);
        step(0, G, R, R, R);
        check_out("short.hold", 0, 3'd0, 2'd0, 0);
        step(0, R, R, R, R);
        check_out("short", 1, 3'd5, 2'd0, 0);

        // Green held exactly MIN_GREEN cycles is accepted.
        do_reset();
        step(0, Y, R, R, R);
        step(0, G, R, R, R);
        step(0, G, R, R, R);
        step(0, G, R, R, R);
        step(0, R, R, R, R);
        check_out("mingreen.ok", 0, 3'd0, 2'd0, 0);

        // Watchdog: all red; 15 samples are fine, the 16th faults.
        do_reset();
        for (int unsigned i = 0; i < 15; i++) step(0, R, R, R, R);
        check_out("timeout.15", 0, 3'd0, 2'd0, 0);
        step(0, R, R, R, R);
        check_out("timeout", 1, 3'd6, 2'd0, 0);
        step(1, R, R, R, R);
        check_out("timeout.rst", 0, 3'd0, 2'd0, 0);
        chk("timeout.rst.rotations", rotations, 8'd0);
        step(0, Y, R, R, R);
        step(0, G, R, R, R);
        check_out("after_rst.grant", 0, 3'd0, 2'd0, 1);
        chk("after_rst.rotations", rotations, 8'd1);

        // Blinking yellow on W before its green: no fault, one grant.
        do_reset();
        step(0, Y, R, R, R);
        step(0, G, R, R, R);
        step(0, G, R, R, R);
        step(0, G, R, R, R);
        step(0, R, Y, R, R);
        grants = 0;
        for (int unsigned i = 0; i < 6; i++) step(0, R, (i % 2 == 0) ? D : Y, R, R);
        check_out("blink.pre", 0, 3'd0, 2'd0, 0);
        step(0, R, G, R, R);
        check_out("blink.green", 0, 3'd0, 2'd0, 1);
        step(0, R, G, R, R);
        chk("blink.grant_count", 8'(grants), 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
